// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the iterative multiply/divide unit.
//   - MD_* operation codes driven on the op port by the decode stage
//   - md_state_e: control FSM states of muldiv_unit
//   - helpers that classify an op code
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MD_S_IDLE = 2'b00,
    MD_S_RUN  = 2'b01,
    MD_S_FIX  = 2'b10
  } md_state_e;

  // Arithmetic ops occupy 000..011; bit 0 clear selects the signed variant.
  function automatic logic md_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return ~op[2] & ~op[0];
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the execute stage and muldiv_unit.
//   start, op, a, b : request from the pipeline (master drives)
//   busy, done      : handshake status (slave drives)
//   hi, lo          : architectural HI/LO registers (slave drives)
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned iterative datapath for muldiv_unit.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load operand magnitudes and start iterating
//   i_is_div   : 1 = restoring divide (1 bit/cycle), 0 = shift-add multiply
//   i_mag_a    : multiplicand / dividend magnitude
//   i_mag_b    : multiplier / divisor magnitude
//   o_done     : one-cycle pulse after the last iteration
//   o_hi, o_lo : product {hi,lo}, or remainder (hi) and quotient (lo)
module muldiv_core #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned MUL_RADIX_LOG2 = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_mag_a,
  input  logic [WIDTH-1:0] i_mag_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned Radix = MUL_RADIX_LOG2;
  localparam int unsigned CntW  = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] MulLast = CntW'(WIDTH / Radix - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

  // r_hi: accumulator / partial remainder; r_lo: multiplier / dividend shifting
  // out while product bits / quotient bits shift in; r_opd: multiplicand / divisor.
  logic [WIDTH-1:0] r_hi, r_lo, r_opd;
  logic [CntW-1:0]  r_cnt;
  logic             r_active, r_is_div, r_done;

  logic [WIDTH+Radix-1:0] w_mul_sum;
  logic [WIDTH:0]         w_div_shift, w_div_diff;
  logic [WIDTH-1:0]       w_next_hi, w_next_lo;
  logic                   w_last;

  always_comb begin
    // Add multiplicand * (low Radix multiplier bits), then shift the pair right.
    w_mul_sum   = {{Radix{1'b0}}, r_hi}
                + ({{Radix{1'b0}}, r_opd} * {{WIDTH{1'b0}}, r_lo[Radix-1:0]});
    // Restoring step: keep the trial difference only if it did not borrow.
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opd};
    if (r_is_div) begin
      w_next_hi = w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
      w_next_lo = {r_lo[WIDTH-2:0], ~w_div_diff[WIDTH]};
    end else begin
      w_next_hi = w_mul_sum[WIDTH+Radix-1:Radix];
      w_next_lo = {w_mul_sum[Radix-1:0], r_lo[WIDTH-1:Radix]};
    end
    w_last = (r_cnt == (r_is_div ? DivLast : MulLast));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_hi     <= '0;
        r_lo     <= i_is_div ? i_mag_a : i_mag_b;
        r_opd    <= i_is_div ? i_mag_b : i_mag_a;
        r_cnt    <= '0;
        r_active <= 1'b1;
        r_is_div <= i_is_div;
      end else if (r_active) begin
        r_hi <= w_next_hi;
        r_lo <= w_next_lo;
        if (w_last) begin
          r_cnt    <= '0;
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO owner executing MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//   clk, rst : clock, synchronous active-high reset (aborts any operation)
//   bus      : muldiv_unit_if slave; start/op/a/b request, busy/done handshake,
//              hi/lo registered architectural results
// Arithmetic ops take N+2 cycles from the start edge to done (N = WIDTH for
// divide, WIDTH/MUL_RADIX_LOG2 for multiply). Requests while busy are dropped.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned MUL_RADIX_LOG2 = 1
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  md_state_e        r_state;
  logic [WIDTH-1:0] r_hi, r_lo, r_a;
  logic             r_busy, r_done;
  logic             r_is_div, r_neg_q, r_neg_r, r_div0;

  logic             w_signed, w_load;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_core_done;
  logic [WIDTH-1:0] w_core_hi, w_core_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_fix_hi, w_fix_lo;

  always_comb begin
    w_signed = md_is_signed(bus.op);
    w_mag_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_mag_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    w_load   = (r_state == MD_S_IDLE) && bus.start && md_is_arith(bus.op);
  end

  muldiv_core #(
    .WIDTH          (WIDTH),
    .MUL_RADIX_LOG2 (MUL_RADIX_LOG2)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_is_div (md_is_div(bus.op)),
    .i_mag_a  (w_mag_a),
    .i_mag_b  (w_mag_b),
    .o_done   (w_core_done),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  // Sign correction on the unsigned core result. MIN_INT / -1 needs no special
  // case: the quotient magnitude 2^(WIDTH-1) is already the required bit pattern.
  always_comb begin
    w_prod   = {w_core_hi, w_core_lo};
    w_fix_hi = w_core_hi;
    w_fix_lo = w_core_lo;
    if (!r_is_div) begin
      if (r_neg_q) begin
        w_prod = -w_prod;
      end
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else if (r_div0) begin
      w_fix_hi = r_a;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = r_neg_r ? -w_core_hi : w_core_hi;
      w_fix_lo = r_neg_q ? -w_core_lo : w_core_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= MD_S_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_S_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MD_MTHI: r_hi <= bus.a;
              MD_MTLO: r_lo <= bus.a;
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                r_state  <= MD_S_RUN;
                r_busy   <= 1'b1;
                r_is_div <= md_is_div(bus.op);
                r_neg_q  <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_neg_r  <= w_signed & bus.a[WIDTH-1];
                r_div0   <= md_is_div(bus.op) & (bus.b == '0);
                r_a      <= bus.a;
              end
              default: ;
            endcase
          end
        end
        MD_S_RUN: begin
          if (w_core_done) begin
            r_state <= MD_S_FIX;
          end
        end
        MD_S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= MD_S_IDLE;
        end
        default: r_state <= MD_S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit, a 32-bit radix-1 instance and a
// 16-bit radix-2 instance sharing one clock.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(16)) bus16 ();

  muldiv_unit #(.WIDTH(32), .MUL_RADIX_LOG2(1)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  muldiv_unit #(.WIDTH(16), .MUL_RADIX_LOG2(2)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge (E0); returns 1 time unit after E0.
  task automatic go32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
  endtask

  task automatic go16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus16.start = 1'b1;
    bus16.op    = op;
    bus16.a     = a;
    bus16.b     = b;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
  endtask

  // Edges after E0 until done is seen; 0 if it never arrives within the budget.
  task automatic wait_done(input bit is16, output int cycles);
    cycles = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (is16 ? bus16.done : bus32.done) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus32.start = 1'b0; bus32.op = 3'b000; bus32.a = '0; bus32.b = '0;
    bus16.start = 1'b0; bus16.op = 3'b000; bus16.a = '0; bus16.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi32", bus32.hi, 0);
    check("rst_lo32", bus32.lo, 0);
    check("rst_busy32", bus32.busy, 0);
    check("rst_done32", bus32.done, 0);
    check("rst_hi16", bus16.hi, 0);
    @(negedge clk);
    rst = 1'b0;

    // MULT -3 * 5
    go32(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy", bus32.busy, 1);
    wait_done(1'b0, cyc);
    check("mult_lat", cyc, 34);
    check("mult_hi", bus32.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus32.lo, 32'hFFFF_FFF1);
    check("mult_busy_end", bus32.busy, 0);
    @(posedge clk);
    #1;
    check("mult_done_pulse", bus32.done, 0);
    check("mult_lo_hold", bus32.lo, 32'hFFFF_FFF1);

    go32(MD_MULTU, 32'hFFFF_FFFD, 32'd5);
    wait_done(1'b0, cyc);
    check("multu_lat", cyc, 34);
    check("multu_hi", bus32.hi, 32'h0000_0004);
    check("multu_lo", bus32.lo, 32'hFFFF_FFF1);

    go32(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(1'b0, cyc);
    check("div_lat", cyc, 34);
    check("div_q", bus32.lo, 32'hFFFF_FFFD);
    check("div_r", bus32.hi, 32'hFFFF_FFFF);

    go32(MD_DIVU, 32'd7, 32'd2);
    wait_done(1'b0, cyc);
    check("divu_q", bus32.lo, 32'd3);
    check("divu_r", bus32.hi, 32'd1);

    go32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, cyc);
    check("div_ovf_q", bus32.lo, 32'h8000_0000);
    check("div_ovf_r", bus32.hi, 32'd0);

    go32(MD_DIVU, 32'h0000_1234, 32'd0);
    wait_done(1'b0, cyc);
    check("divu0_lat", cyc, 34);
    check("divu0_q", bus32.lo, 32'hFFFF_FFFF);
    check("divu0_r", bus32.hi, 32'h0000_1234);

    go32(MD_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done(1'b0, cyc);
    check("div0_q", bus32.lo, 32'hFFFF_FFFF);
    check("div0_r", bus32.hi, 32'hFFFF_FFFB);

    // MTHI while idle, then a reserved op that must change nothing.
    go32(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("mthi_hi", bus32.hi, 32'hDEAD_BEEF);
    check("mthi_busy", bus32.busy, 0);
    check("mthi_done", bus32.done, 0);
    go32(3'b110, 32'h1111_1111, 32'h2222_2222);
    @(posedge clk);
    #1;
    check("rsvd_busy", bus32.busy, 0);
    check("rsvd_hi", bus32.hi, 32'hDEAD_BEEF);
    check("rsvd_lo", bus32.lo, 32'hFFFF_FFFF);

    // MULTU with MTLO and a second start issued while busy; operands then change.
    go32(MD_MULTU, 32'h0001_0003, 32'h0002_0005);
    go32(MD_MTLO, 32'h5555_5555, 32'd0);
    check("busy_mtlo_lo", bus32.lo, 32'hFFFF_FFFF);
    go32(MD_MULT, 32'd7, 32'd9);
    check("busy_hi_hold", bus32.hi, 32'hDEAD_BEEF);
    wait_done(1'b0, cyc);
    check("busy_lat", cyc, 32);
    check("busy_prod_hi", bus32.hi, 32'h0000_0002);
    check("busy_prod_lo", bus32.lo, 32'h000B_000F);
    @(posedge clk);
    #1;
    check("busy_2nd_start", bus32.busy, 0);

    // Reset in the middle of a DIVU.
    go32(MD_DIVU, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", bus32.busy, 0);
    check("abort_done", bus32.done, 0);
    check("abort_hi", bus32.hi, 0);
    check("abort_lo", bus32.lo, 0);
    @(negedge clk);
    rst = 1'b0;
    go32(MD_MULTU, 32'd6, 32'd7);
    wait_done(1'b0, cyc);
    check("post_rst_lat", cyc, 34);
    check("post_rst_lo", bus32.lo, 32'd42);
    check("post_rst_hi", bus32.hi, 32'd0);

    // 16-bit radix-2 instance.
    go16(MD_MULTU, 16'hFFFF, 16'hFFFF);
    wait_done(1'b1, cyc);
    check("r2_multu_lat", cyc, 10);
    check("r2_multu_hi", bus16.hi, 16'hFFFE);
    check("r2_multu_lo", bus16.lo, 16'h0001);

    go16(MD_MULT, 16'hFFFE, 16'd3);
    wait_done(1'b1, cyc);
    check("r2_mult_hi", bus16.hi, 16'hFFFF);
    check("r2_mult_lo", bus16.lo, 16'hFFFA);

    go16(MD_DIV, 16'hFFF9, 16'd2);
    wait_done(1'b1, cyc);
    check("r2_div_lat", cyc, 18);
    check("r2_div_q", bus16.lo, 16'hFFFD);
    check("r2_div_r", bus16.hi, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative integer multiply/divide unit for the MIPS150 datapath.
- Owns the HI/LO architectural registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the combinational ALU in the execute stage.
- Is parametrised in operand width and in multiply radix, and adds a start/busy/done handshake that lets the pipeline stall MFHI/MFLO until results are ready.

Parameters:
- WIDTH, 32: operand width and width of each of HI and LO.
- MUL_RADIX_LOG2, 1: multiplier bits retired per cycle (1 or 2); divide is always 1 bit per cycle.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only when busy=0
- op  input  3  operation code (MD_* constants)
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  multi-cycle operation in progress
- done  output  1  one-cycle pulse; HI/LO hold the new result
- hi  output  WIDTH  HI register (product high half / remainder)
- lo  output  WIDTH  LO register (product low half / quotient)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. Reset mid-operation aborts the operation with no partial HI/LO update. rst has priority over start.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op MD_MTHI/MD_MTLO: hi (resp. lo) <= a at that edge; stays IDLE; busy and done stay 0.
  - start=1 with MD_MULT/MULTU/DIV/DIVU: latches operand magnitudes (signed ops take the absolute value; result sign = sign(a)^sign(b); remainder sign = sign(a)), clears the accumulator, goes to RUN, busy=1 from the next cycle.
  - Reserved op codes (110, 111) are ignored.
- RUN:
  - Multiply: shift-add, MUL_RADIX_LOG2 bits per cycle, for N=WIDTH/2^(MUL_RADIX_LOG2-1)... precisely WIDTH>>(MUL_RADIX_LOG2-1)... i.e. N=WIDTH/MUL_RADIX_LOG2 cycles.
  - Divide: restoring, 1 bit per cycle, N=WIDTH cycles.
  - After the Nth cycle, goes to FIX.
- FIX (one cycle): applies sign correction; at the end of FIX, hi/lo are written. The next state is IDLE with done=1 for exactly that one cycle and busy=0.
- Latency: start sampled at edge E0 -> hi/lo valid and done=1 after edge E(N+2). For WIDTH=32, radix-1 multiply or divide, that is 34 cycles.
- start or MTHI/MTLO while busy=1: ignored; HI/LO are unaffected until completion. The pipeline must stall.
- a and b are sampled only at E0; later changes have no effect.
- Product width is 2*WIDTH: {hi,lo} = a*b, signed or unsigned per op.
- Division: lo=quotient truncated toward zero; hi=remainder carrying the sign of the dividend.
- Divide by zero (DIV or DIVU): lo=all ones, hi=a, same latency.
- Signed overflow (MIN_INT / -1): lo=MIN_INT, hi=0.
- hi and lo are registered outputs and hold their value in all non-writing cycles.

Decomposition:
- Shared header MulDivop.vh, alongside the ALUop header:
  - MD_MULT=3'b000, MD_MULTU=3'b001, MD_DIV=3'b010, MD_DIVU=3'b011, MD_MTHI=3'b100, MD_MTLO=3'b101.
  - State encodings MD_S_IDLE, MD_S_RUN, MD_S_FIX.
- One natural sub-module: muldiv_core, the iterative shift-add/restoring-divide datapath with its counter. muldiv_unit keeps the FSM, sign handling and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, done exactly 34 cycles after start.
- MTHI a=0xDEADBEEF while idle -> hi=0xDEADBEEF next cycle, done=0, busy=0. Then start MULTU and issue MTLO/start while busy -> ignored; final lo equals the product.
- Assert rst at cycle 10 of a DIVU -> next cycle busy=0, done=0, hi=lo=0; a new MULTU 6*7 then yields lo=42, hi=0.
- MUL_RADIX_LOG2=2, WIDTH=16: MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001, done 10 cycles after start.
